// File: rtl/dev_ram_mc_pkg.sv
// dev_ram_mc_pkg: shared types, size constants and lane helpers for the RAM device.
//   op_t        - request operation (RAM_NONE / RAM_FETCH / RAM_STORE)
//   data_type_t - access size (RAM_BYTE / RAM_WORD / RAM_LONG / RAM_QUAD)
//   ram_*       - big-endian long lane helpers: byte enables, store shift, fetch extract/extend
package dev_ram_mc_pkg;

  typedef enum logic [1:0] {
    RAM_NONE  = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2,
    RAM_QUAD = 2'd3
  } data_type_t;

  localparam int unsigned RAM_BYTE_BITS = 8;
  localparam int unsigned RAM_WORD_BITS = 16;
  localparam int unsigned RAM_LONG_BITS = 32;
  localparam int unsigned RAM_QUAD_BITS = 64;

  localparam int unsigned SPRAM_WIDTH = 16;

  // Alignment check on the low three address bits.
  function automatic logic ram_aligned(data_type_t t, logic [2:0] a);
    logic ok;
    unique case (t)
      RAM_BYTE: ok = 1'b1;
      RAM_WORD: ok = !a[0];
      RAM_LONG: ok = (a[1:0] == 2'b00);
      default:  ok = (a == 3'b000);
    endcase
    return ok;
  endfunction

  // Byte-lane enables; bit i covers long bits [8i+7:8i], so offset 0 is bit 3.
  function automatic logic [3:0] ram_byte_en(data_type_t t, logic [1:0] off);
    logic [3:0] be;
    unique case (t)
      RAM_BYTE: be = 4'b1000 >> off;
      RAM_WORD: be = off[1] ? 4'b0011 : 4'b1100;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across the long so the byte enables pick the right lane.
  function automatic logic [RAM_LONG_BITS-1:0] ram_long_shift(data_type_t t,
                                                             logic [RAM_LONG_BITS-1:0] d);
    logic [RAM_LONG_BITS-1:0] r;
    unique case (t)
      RAM_BYTE: r = {4{d[RAM_BYTE_BITS-1:0]}};
      RAM_WORD: r = {2{d[RAM_WORD_BITS-1:0]}};
      default:  r = d;
    endcase
    return r;
  endfunction

  // Pull the addressed byte/word out of a big-endian long, zero-filled.
  function automatic logic [RAM_LONG_BITS-1:0] ram_long_extract(data_type_t t, logic [1:0] off,
                                                               logic [RAM_LONG_BITS-1:0] l);
    logic [RAM_LONG_BITS-1:0] r;
    r = '0;
    unique case (t)
      RAM_BYTE: begin
        unique case (off)
          2'd0:    r[RAM_BYTE_BITS-1:0] = l[31:24];
          2'd1:    r[RAM_BYTE_BITS-1:0] = l[23:16];
          2'd2:    r[RAM_BYTE_BITS-1:0] = l[15:8];
          default: r[RAM_BYTE_BITS-1:0] = l[7:0];
        endcase
      end
      RAM_WORD: r[RAM_WORD_BITS-1:0] = off[1] ? l[15:0] : l[31:16];
      default:  r = l;
    endcase
    return r;
  endfunction

  function automatic logic [RAM_QUAD_BITS-1:0] ram_zext(logic [RAM_LONG_BITS-1:0] l);
    return {{(RAM_QUAD_BITS - RAM_LONG_BITS){1'b0}}, l};
  endfunction

endpackage

// File: rtl/ram_set.sv
// ram_set: one 32-bit long lane built from two 16-bit SPRAMs (high half, low half).
//   clk   - clock
//   tag   - long address within the set
//   be    - byte enables, bit i covers data bits [8i+7:8i]; all zero means read only
//   wdata - long write data
//   rdata - long read data, one cycle after tag
module ram_set
  import dev_ram_mc_pkg::*;
#(
  parameter int unsigned SPRAM_ADDRW = 14
) (
  input  logic                   clk,
  input  logic [SPRAM_ADDRW-1:0] tag,
  input  logic [3:0]             be,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata
);

  logic [SPRAM_WIDTH-1:0] rdata_hi;
  logic [SPRAM_WIDTH-1:0] rdata_lo;

  // Each byte enable drives the two nibble masks of its byte.
  spram #(
    .ADDRW(SPRAM_ADDRW),
    .WIDTH(SPRAM_WIDTH)
  ) u_hi (
    .clk      (clk),
    .addr     (tag),
    .wdata    (wdata[2*SPRAM_WIDTH-1:SPRAM_WIDTH]),
    .maskwren ({be[3], be[3], be[2], be[2]}),
    .wren     (|be[3:2]),
    .rdata    (rdata_hi)
  );

  spram #(
    .ADDRW(SPRAM_ADDRW),
    .WIDTH(SPRAM_WIDTH)
  ) u_lo (
    .clk      (clk),
    .addr     (tag),
    .wdata    (wdata[SPRAM_WIDTH-1:0]),
    .maskwren ({be[1], be[1], be[0], be[0]}),
    .wren     (|be[1:0]),
    .rdata    (rdata_lo)
  );

  assign rdata = {rdata_hi, rdata_lo};

endmodule

// File: rtl/spram.sv
// spram: single-port RAM primitive model with nibble write masks and registered read.
//   clk      - clock
//   addr     - word address
//   wdata    - write data
//   maskwren - per-nibble write enable (bit n covers wdata[4n+3:4n])
//   wren     - write strobe
//   rdata    - read data, valid the cycle after addr is presented
module spram #(
  parameter int unsigned ADDRW = 14,
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic [ADDRW-1:0]     addr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/4-1:0]   maskwren,
  input  logic                 wren,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDRW];
  logic [WIDTH-1:0] rdata_q;

  // Read returns the pre-write contents on a same-address write.
  always_ff @(posedge clk) begin
    if (wren) begin
      for (int n = 0; n < int'(WIDTH / 4); n++) begin
        if (maskwren[n]) begin
          mem_q[addr][4*n +: 4] <= wdata[4*n +: 4];
        end
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dev_ram_mc.sv
// dev_ram_mc: multi-cycle big-endian RAM device, byte/word/long/quad fetch and store.
// Optional feature macro: RAM_QUAD_EN (quad accesses as two long beats; QUAD1 state + hold reg).
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - request present;   req_ready - request accepted on valid && ready
//   req_op     - op_t;              req_type  - data_type_t
//   req_addr   - byte address;      req_data  - store data (low bits for sub-quad sizes)
//   rsp_valid  - one-cycle response pulse, no backpressure
//   rsp_err    - request rejected, nothing written
//   rsp_data   - zero-extended fetch result, 0 otherwise
module dev_ram_mc
  import dev_ram_mc_pkg::*;
#(
  parameter int unsigned SETS        = 2,
  parameter int unsigned SPRAM_ADDRW = 14,
  localparam int unsigned RAM_ADDRW  = SPRAM_ADDRW + 2 + $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [1:0]           req_type,
  input  logic [RAM_ADDRW-1:0] req_addr,
  input  logic [63:0]          req_data,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [63:0]          rsp_data
);

  localparam int unsigned SetW = (SETS > 1) ? $clog2(SETS) : 1;

`ifdef RAM_QUAD_EN
  localparam bit QuadEn = 1'b1;
`else
  localparam bit QuadEn = 1'b0;
`endif

  // Request decode.
  op_t                    req_op_e;
  data_type_t             req_type_e;
  logic [1:0]             req_off;
  logic [SPRAM_ADDRW-1:0] req_tag;
  logic [SetW-1:0]        req_set;
  logic                   req_fetch;
  logic                   req_store;
  logic                   req_quad;
  logic                   req_err;
  logic                   accept;

  assign req_op_e   = op_t'(req_op);
  assign req_type_e = data_type_t'(req_type);
  assign req_off    = req_addr[1:0];
  assign req_tag    = req_addr[SPRAM_ADDRW+1:2];
  assign req_set    = SetW'(req_addr >> (SPRAM_ADDRW + 2));
  assign req_fetch  = (req_op_e == RAM_FETCH);
  assign req_store  = (req_op_e == RAM_STORE);
  assign req_quad   = (req_type_e == RAM_QUAD);
  assign req_err    = !(req_fetch || req_store) || !ram_aligned(req_type_e, req_addr[2:0]) ||
                      (req_quad && !QuadEn);
  assign accept     = req_valid && req_ready;

  // SPRAM array interface.
  logic [SPRAM_ADDRW-1:0] ram_addr;
  logic [SetW-1:0]        ram_sel;
  logic [31:0]            ram_wdata;
  logic [3:0]             ram_be;
  logic [31:0]            ram_rdata [SETS];

  // Response-side registers.
  logic       rsp_valid_d, rsp_valid_q;
  logic       rsp_err_d, rsp_err_q;
  logic       fetch_d, fetch_q;
  data_type_t type_d, type_q;
  logic [1:0] off_d, off_q;
  logic [SetW-1:0] set_d, set_q;

`ifdef RAM_QUAD_EN
  typedef enum logic [0:0] {StIdle, StQuad1} state_e;
  state_e                 state_d, state_q;
  logic [31:0]            hold_d, hold_q;
  logic [SPRAM_ADDRW-1:0] tag_d, tag_q;
  logic [31:0]            lo_d, lo_q;

  assign req_ready = !rst && (state_q == StIdle);
`else
  logic unused_quad_data;
  assign unused_quad_data = ^req_data[63:32];
  assign req_ready = !rst;
`endif

  always_comb begin
    ram_addr    = req_tag;
    ram_sel     = req_set;
    ram_wdata   = ram_long_shift(req_type_e, req_data[31:0]);
    ram_be      = 4'h0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    fetch_d     = fetch_q;
    type_d      = type_q;
    off_d       = off_q;
    set_d       = set_q;
`ifdef RAM_QUAD_EN
    state_d     = state_q;
    hold_d      = hold_q;
    tag_d       = tag_q;
    lo_d        = lo_q;
`endif

    if (accept) begin
      // Errors clear fetch so rsp_data stays 0 on the error pulse.
      fetch_d     = req_fetch && !req_err;
      type_d      = req_type_e;
      off_d       = req_off;
      set_d       = req_set;
      rsp_valid_d = 1'b1;
      rsp_err_d   = req_err;
      if (req_store && !req_err) begin
        ram_be = ram_byte_en(req_type_e, req_off);
      end
`ifdef RAM_QUAD_EN
      if (req_quad && !req_err) begin
        // Beat 0 carries the high long; response waits for beat 1.
        rsp_valid_d = 1'b0;
        ram_wdata   = req_data[63:32];
        // Quad alignment guarantees tag bit 0 is clear, so this is tag + 1.
        tag_d       = {req_tag[SPRAM_ADDRW-1:1], 1'b1};
        lo_d        = req_data[31:0];
        state_d     = StQuad1;
      end
`endif
    end

`ifdef RAM_QUAD_EN
    if (state_q == StQuad1) begin
      ram_addr    = tag_q;
      ram_sel     = set_q;
      ram_wdata   = lo_q;
      // Reset in this cycle suppresses the second write.
      ram_be      = (!fetch_q && !rst) ? 4'hF : 4'h0;
      hold_d      = ram_rdata[set_q];
      rsp_valid_d = 1'b1;
      state_d     = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      fetch_q     <= 1'b0;
      type_q      <= RAM_BYTE;
      off_q       <= 2'b00;
      set_q       <= '0;
`ifdef RAM_QUAD_EN
      state_q     <= StIdle;
      hold_q      <= '0;
      tag_q       <= '0;
      lo_q        <= '0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      fetch_q     <= fetch_d;
      type_q      <= type_d;
      off_q       <= off_d;
      set_q       <= set_d;
`ifdef RAM_QUAD_EN
      state_q     <= state_d;
      hold_q      <= hold_d;
      tag_q       <= tag_d;
      lo_q        <= lo_d;
`endif
    end
  end

  for (genvar s = 0; s < int'(SETS); s++) begin : g_set
    ram_set #(
      .SPRAM_ADDRW(SPRAM_ADDRW)
    ) u_set (
      .clk   (clk),
      .tag   (ram_addr),
      .be    ((ram_sel == SetW'(s)) ? ram_be : 4'h0),
      .wdata (ram_wdata),
      .rdata (ram_rdata[s])
    );
  end

  logic [31:0] rd_long;

  always_comb begin
    rsp_data = '0;
    rd_long  = ram_rdata[set_q];
    if (rsp_valid_q && fetch_q) begin
      rsp_data = ram_zext(ram_long_extract(type_q, off_q, rd_long));
`ifdef RAM_QUAD_EN
      if (type_q == RAM_QUAD) begin
        rsp_data = {hold_q, rd_long};
      end
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dev_ram_mc.sv
// tb_dev_ram_mc: directed scoreboard bench for dev_ram_mc (default SETS=2, SPRAM_ADDRW=14).
module tb_dev_ram_mc;
  import dev_ram_mc_pkg::*;

  localparam int unsigned AW = 17;
`ifdef RAM_QUAD_EN
  localparam bit QE = 1'b1;
`else
  localparam bit QE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [1:0]    req_type;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_data;
  logic          rsp_valid;
  logic          rsp_err;
  logic [63:0]   rsp_data;

  always #5 clk = ~clk;

  dev_ram_mc #(
    .SETS       (2),
    .SPRAM_ADDRW(14)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data)
  );

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 err=%b data=%h, expected no response",
                   rsp_err, rsp_data);
        end else begin
          exp_t  e;
          string nm;
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_err"}, 64'(rsp_err), 64'(e.err));
          check({nm, "_data"}, rsp_data, e.data);
          check({nm, "_latency"}, 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("idle_rsp", {rsp_valid, rsp_err, rsp_data}, 66'd0);
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, then queue its expected response.
  task automatic issue(string nm, logic [1:0] op, logic [1:0] typ, logic [AW-1:0] addr,
                       logic [63:0] data, logic exp_err, logic [63:0] exp_data,
                       int lat, bit expect_rsp);
    bit ok;
    req_valid = 1'b1;
    req_op    = op;
    req_type  = typ;
    req_addr  = addr;
    req_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = (req_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: req_ready never high, expected acceptance within 8 cycles", nm);
    end else if (expect_rsp) begin
      exp_q.push_back('{err: exp_err, data: exp_data, cyc: cyc + lat});
      name_q.push_back(nm);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_type = 2'd0;
    req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'd1);
    mon_en = 1'b1;

    // Long store, then sub-long fetches in big-endian lanes.
    issue("st_long10", RAM_STORE, RAM_LONG, 17'h00010, 64'hDEADBEEF, 0, 0, 0, 1);
    issue("ld_byte11", RAM_FETCH, RAM_BYTE, 17'h00011, 0, 0, 64'hAD, 0, 1);
    issue("ld_word12", RAM_FETCH, RAM_WORD, 17'h00012, 0, 0, 64'hBEEF, 0, 1);
    issue("ld_byte13", RAM_FETCH, RAM_BYTE, 17'h00013, 0, 0, 64'hEF, 0, 1);
    issue("ld_word10", RAM_FETCH, RAM_WORD, 17'h00010, 0, 0, 64'hDEAD, 0, 1);

    // Set 1 byte store leaves set 0 at the same tag alone.
    issue("st_long0", RAM_STORE, RAM_LONG, 17'h00000, 64'hCAFEF00D, 0, 0, 0, 1);
    issue("st_long1k", RAM_STORE, RAM_LONG, 17'h10000, 64'h11223344, 0, 0, 0, 1);
    issue("st_byte1k3", RAM_STORE, RAM_BYTE, 17'h10003, 64'h5A, 0, 0, 0, 1);
    issue("ld_long1k", RAM_FETCH, RAM_LONG, 17'h10000, 0, 0, 64'h1122335A, 0, 1);
    issue("ld_long0", RAM_FETCH, RAM_LONG, 17'h00000, 0, 0, 64'hCAFEF00D, 0, 1);
    issue("st_word1k0", RAM_STORE, RAM_WORD, 17'h10000, 64'hA5A5, 0, 0, 0, 1);
    issue("ld_long1k_b", RAM_FETCH, RAM_LONG, 17'h10000, 0, 0, 64'hA5A5335A, 0, 1);

    // Quad store/fetch (error response when the feature is absent).
    issue("st_long20", RAM_STORE, RAM_LONG, 17'h00020, 64'h0BADC0DE, 0, 0, 0, 1);
    issue("st_long24", RAM_STORE, RAM_LONG, 17'h00024, 64'h600DF00D, 0, 0, 0, 1);
    issue("st_quad20", RAM_STORE, RAM_QUAD, 17'h00020, 64'h0123456789ABCDEF, !QE, 0,
          QE ? 1 : 0, 1);
    check("quad_ready", 64'(req_ready), QE ? 64'd0 : 64'd1);
    issue("ld_quad20", RAM_FETCH, RAM_QUAD, 17'h00020, 0, !QE,
          QE ? 64'h0123456789ABCDEF : 64'd0, QE ? 1 : 0, 1);
    issue("ld_long24", RAM_FETCH, RAM_LONG, 17'h00024, 0, 0,
          QE ? 64'h89ABCDEF : 64'h600DF00D, 0, 1);
    issue("ld_long20", RAM_FETCH, RAM_LONG, 17'h00020, 0, 0,
          QE ? 64'h01234567 : 64'h0BADC0DE, 0, 1);

    // Misaligned / no-op requests: error pulse, no write.
    issue("ld_word01", RAM_FETCH, RAM_WORD, 17'h00001, 0, 1, 0, 0, 1);
    issue("ld_long02", RAM_FETCH, RAM_LONG, 17'h00002, 0, 1, 0, 0, 1);
    issue("ld_quad04", RAM_FETCH, RAM_QUAD, 17'h00004, 0, 1, 0, 0, 1);
    issue("st_word11", RAM_STORE, RAM_WORD, 17'h00011, 64'hFFFF, 1, 0, 0, 1);
    issue("st_long12", RAM_STORE, RAM_LONG, 17'h00012, 64'hFFFFFFFF, 1, 0, 0, 1);
    issue("st_quad24", RAM_STORE, RAM_QUAD, 17'h00024, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 1);
    issue("none10", RAM_NONE, RAM_LONG, 17'h00010, 64'hFFFFFFFF, 1, 0, 0, 1);
    issue("op3_10", 2'd3, RAM_LONG, 17'h00010, 64'hFFFFFFFF, 1, 0, 0, 1);
    issue("ld_long10", RAM_FETCH, RAM_LONG, 17'h00010, 0, 0, 64'hDEADBEEF, 0, 1);
    issue("ld_long0_b", RAM_FETCH, RAM_LONG, 17'h00000, 0, 0, 64'hCAFEF00D, 0, 1);

    // Back-to-back fetches, one per cycle.
    issue("b2b0", RAM_FETCH, RAM_LONG, 17'h00010, 0, 0, 64'hDEADBEEF, 0, 1);
    issue("b2b1", RAM_FETCH, RAM_LONG, 17'h00000, 0, 0, 64'hCAFEF00D, 0, 1);
    issue("b2b2", RAM_FETCH, RAM_LONG, 17'h10000, 0, 0, 64'hA5A5335A, 0, 1);
    issue("b2b3", RAM_FETCH, RAM_LONG, 17'h00024, 0, 0,
          QE ? 64'h89ABCDEF : 64'h600DF00D, 0, 1);

`ifdef RAM_QUAD_EN
    // Reset while in QUAD1: beat 0 stays written, beat 1 and the response are dropped.
    issue("st_long30", RAM_STORE, RAM_LONG, 17'h00030, 64'hAAAAAAAA, 0, 0, 0, 1);
    issue("st_long34", RAM_STORE, RAM_LONG, 17'h00034, 64'hBBBBBBBB, 0, 0, 0, 1);
    issue("st_quad30", RAM_STORE, RAM_QUAD, 17'h00030, 64'h1111111122222222, 0, 0, 1, 0);
    check("quad1_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_after_quad_rst", 64'(req_ready), 64'd1);
    issue("ld_long30", RAM_FETCH, RAM_LONG, 17'h00030, 0, 0, 64'h11111111, 0, 1);
    issue("ld_long34", RAM_FETCH, RAM_LONG, 17'h00034, 0, 0, 64'hBBBBBBBB, 0, 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("pending_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
